// File: rtl/acc_group_serializer_if.sv
// acc_group_serializer_if: wide-word input stream and element output stream of the serializer.
// master = producer/consumer side, slave = serializer side.
interface acc_group_serializer_if #(
  parameter int unsigned DataWidth       = 32,
  parameter int unsigned AccumulateCount = 4
);
  logic                                 DataInValid;
  logic                                 DataInRdy;
  logic [DataWidth*AccumulateCount-1:0] DataIn;
  logic                                 DataOutValid;
  logic                                 DataOutRdy;
  logic [DataWidth-1:0]                 DataOut;
  logic                                 DataOutLast;

  modport master (
    output DataInValid, DataIn, DataOutRdy,
    input  DataInRdy, DataOutValid, DataOut, DataOutLast
  );

  modport slave (
    input  DataInValid, DataIn, DataOutRdy,
    output DataInRdy, DataOutValid, DataOut, DataOutLast
  );
endinterface

// File: rtl/acc_group_serializer.sv
// acc_group_serializer: buffers packed wide words in a FIFO and emits one element per cycle,
// one group per word. Define SERIALIZER_MSB_FIRST_EN to emit elements from the top index down.
module acc_group_serializer #(
  parameter int unsigned DataWidth            = 32,
  parameter int unsigned AccumulateCount      = 4,
  parameter int unsigned AccumulateCountWidth = 2,
  parameter int unsigned BufferWidth          = 2,
  parameter int unsigned BufferSize           = 4
) (
  input  logic                  clk,
  input  logic                  sclr,
  acc_group_serializer_if.slave bus,
  output logic                  Busy
);
  localparam int unsigned WordWidth = DataWidth * AccumulateCount;
  localparam int unsigned FillWidth = BufferWidth + 1;

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  logic [WordWidth-1:0]            r_mem [BufferSize];
  logic [BufferWidth-1:0]          r_wr_ptr, r_rd_ptr;
  logic [FillWidth-1:0]            r_fill, w_fill_d;
  logic [WordWidth-1:0]            r_word, w_word_d;
  logic [AccumulateCountWidth-1:0] r_cnt, w_cnt_d, w_idx;
  state_e                          r_state, w_state_d;
  logic                            w_full, w_empty, w_push, w_pop, w_send_hs, w_cnt_last;

  // Occupancy count keeps a full FIFO distinguishable from an empty one.
  assign w_full        = (r_fill == FillWidth'(BufferSize));
  assign w_empty       = (r_fill == '0);
  assign bus.DataInRdy = ~w_full;
  assign w_push        = bus.DataInValid & ~w_full;

  assign bus.DataOutValid = (r_state == StSend);
  assign w_send_hs        = bus.DataOutValid & bus.DataOutRdy;
  assign w_cnt_last       = (r_cnt == AccumulateCountWidth'(AccumulateCount - 1));
  assign Busy             = (r_state == StSend) | ~w_empty;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_word_d  = r_word;
    w_pop     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_word_d  = r_mem[r_rd_ptr];
          w_cnt_d   = '0;
          w_state_d = StSend;
        end
      end
      StSend: begin
        if (w_send_hs) begin
          if (!w_cnt_last) begin
            w_cnt_d = r_cnt + AccumulateCountWidth'(1);
          end else begin
            // Explicit wrap; reload straight away so groups stream without a bubble.
            w_cnt_d = '0;
            if (!w_empty) begin
              w_pop    = 1'b1;
              w_word_d = r_mem[r_rd_ptr];
            end else begin
              w_state_d = StIdle;
            end
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_fill_d = r_fill;
    unique case ({w_push, w_pop})
      2'b10:   w_fill_d = r_fill + FillWidth'(1);
      2'b01:   w_fill_d = r_fill - FillWidth'(1);
      default: w_fill_d = r_fill;
    endcase
  end

  always_comb begin
`ifdef SERIALIZER_MSB_FIRST_EN
    w_idx = AccumulateCountWidth'(AccumulateCount - 1) - r_cnt;
`else
    w_idx = r_cnt;
`endif
    bus.DataOut = '0;
    if (r_state == StSend) begin
      for (int unsigned k = 0; k < AccumulateCount; k++) begin
        if (w_idx == AccumulateCountWidth'(k)) bus.DataOut = r_word[k*DataWidth +: DataWidth];
      end
    end
    bus.DataOutLast = (r_state == StSend) & w_cnt_last;
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.DataIn;
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_fill   <= '0;
      r_word   <= '0;
      r_cnt    <= '0;
      r_state  <= StIdle;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + BufferWidth'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + BufferWidth'(1);
      r_fill  <= w_fill_d;
      r_word  <= w_word_d;
      r_cnt   <= w_cnt_d;
      r_state <= w_state_d;
    end
  end
endmodule
